// File: rtl/cnt_seq_checker.sv
// Sequence checker for a free-running counter: tracks +1-per-sample sequencing,
// counts wraps and mismatches, and reports WRAP/ERROR/LOCK events through a small FIFO.
module cnt_seq_checker #(
  parameter int CNT_W      = 4,
  parameter int STAT_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     cnt_in,
  input  logic                 cnt_en,
  input  logic                 clr,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2+2*CNT_W-1:0] evt_data,
  output logic [STAT_W-1:0]    wrap_cnt,
  output logic [STAT_W-1:0]    err_cnt,
  output logic                 locked,
  output logic                 overflow
);

  localparam int EVT_W = 2 + 2 * CNT_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    RESYNC   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   expected, expected_nxt;
  logic               match;
  logic               is_wrap;
  logic               is_err;
  logic               evt_push;
  logic [EVT_W-1:0]   evt_new;

  logic [EVT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr, fill;
  logic               empty, full, do_pop, do_push;

  assign match = (cnt_in == expected);

  // Sample classification: next FSM state, next expected value and event to report
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    is_wrap      = 1'b0;
    is_err       = 1'b0;
    evt_push     = 1'b0;
    evt_new      = '0;
    if (cnt_en) begin
      expected_nxt = cnt_in + CNT_W'(1);
      case (state)
        UNLOCKED: begin
          state_nxt = LOCKED;
          evt_push  = 1'b1;
          evt_new   = {2'b11, cnt_in, cnt_in};
        end
        LOCKED: begin
          if (match) begin
            state_nxt = LOCKED;
            if (cnt_in == '0) begin
              is_wrap  = 1'b1;
              evt_push = 1'b1;
              evt_new  = {2'b01, {CNT_W{1'b0}}, {CNT_W{1'b0}}};
            end else begin
              is_wrap  = 1'b0;
            end
          end else begin
            state_nxt = RESYNC;
            is_err    = 1'b1;
            evt_push  = 1'b1;
            evt_new   = {2'b10, expected, cnt_in};
          end
        end
        RESYNC: begin
          evt_push = 1'b1;
          if (match) begin
            state_nxt = LOCKED;
            evt_new   = {2'b11, cnt_in, cnt_in};
          end else begin
            state_nxt = RESYNC;
            is_err    = 1'b1;
            evt_new   = {2'b10, expected, cnt_in};
          end
        end
        default: begin
          state_nxt = UNLOCKED;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  assign fill    = wr_ptr - rd_ptr;
  assign empty   = (fill == '0);
  assign full    = (fill == (PTR_W+1)'(FIFO_DEPTH));
  assign do_pop  = !empty && evt_ready && !clr;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = evt_push && !clr && (!full || do_pop);

  // FSM, statistics, overflow flag and FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= UNLOCKED;
      expected <= '0;
      wrap_cnt <= '0;
      err_cnt  <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (clr) begin
      state    <= UNLOCKED;
      expected <= '0;
      wrap_cnt <= '0;
      err_cnt  <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      expected <= expected_nxt;
      if (is_wrap && (wrap_cnt != {STAT_W{1'b1}})) wrap_cnt <= wrap_cnt + STAT_W'(1);
      if (is_err && (err_cnt != {STAT_W{1'b1}}))   err_cnt  <= err_cnt + STAT_W'(1);
      if (evt_push && !do_push) overflow <= 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
    end
  end

  // FIFO storage; contents are only visible through the occupancy-qualified read mux
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= evt_new;
  end

  assign evt_valid = !empty;
  assign evt_data  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  assign locked    = (state == LOCKED);

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Randomized and directed bench for cnt_seq_checker against an event-level reference model.
module tb_cnt_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       cnt_en = 1'b0;
  logic       clr = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [9:0] evt_data;
  logic [15:0] wrap_cnt, err_cnt;
  logic       locked, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // model: mode 0 = no lock yet, 1 = in sequence, 2 = lost sequence
  int         m_mode = 0;
  int         m_last = 0;
  int         m_wrap = 0;
  int         m_err  = 0;
  bit         m_ovf  = 1'b0;
  logic [9:0] m_q[$];

  cnt_seq_checker #(.CNT_W(4), .STAT_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_en(cnt_en), .clr(clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .wrap_cnt(wrap_cnt), .err_cnt(err_cnt), .locked(locked), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_last = 0; m_wrap = 0; m_err = 0; m_ovf = 1'b0;
    m_q.delete();
  endtask

  task automatic model_edge();
    bit         pop;
    bit         has_ev;
    logic [9:0] ev;
    logic [3:0] e4;
    int         exp_v;
    if (reset || clr) begin
      model_clear();
      return;
    end
    pop    = (m_q.size() > 0) && evt_ready;
    has_ev = 1'b0;
    ev     = 10'd0;
    if (cnt_en) begin
      exp_v = (m_last + 1) % 16;
      e4    = exp_v[3:0];
      if (m_mode == 0) begin
        has_ev = 1'b1; ev = {2'b11, cnt_in, cnt_in}; m_mode = 1;
      end else if (int'(cnt_in) == exp_v) begin
        if (m_mode == 2) begin
          has_ev = 1'b1; ev = {2'b11, cnt_in, cnt_in}; m_mode = 1;
        end else if (cnt_in == 4'd0 && m_last == 15) begin
          has_ev = 1'b1; ev = 10'h100;
          if (m_wrap < 65535) m_wrap++;
        end
      end else begin
        has_ev = 1'b1; ev = {2'b10, e4, cnt_in}; m_mode = 2;
        if (m_err < 65535) m_err++;
      end
      m_last = int'(cnt_in);
    end
    if (pop) void'(m_q.pop_front());
    if (has_ev) begin
      if (m_q.size() < 4) m_q.push_back(ev);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    cmp("evt_valid", int'(evt_valid), int'(m_q.size() > 0));
    cmp("evt_data",  int'(evt_data),  (m_q.size() > 0) ? int'(m_q[0]) : 0);
    cmp("wrap_cnt",  int'(wrap_cnt),  m_wrap);
    cmp("err_cnt",   int'(err_cnt),   m_err);
    cmp("locked",    int'(locked),    int'(m_mode == 1));
    cmp("overflow",  int'(overflow),  int'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic sample(input logic [3:0] v);
    cnt_en = 1'b1; cnt_in = v;
    step();
  endtask

  initial begin
    logic [3:0] seq;
    #12;
    cmp("reset_valid", int'(evt_valid), 0);
    cmp("reset_locked", int'(locked), 0);
    reset = 1'b0;
    #4;

    // 1: full count and wrap
    evt_ready = 1'b1;
    sample(4'd0);
    cmp("lit_lock0", int'(evt_data), 'h300);
    for (int i = 1; i < 16; i++) sample(4'(i));
    sample(4'd0);
    cmp("lit_wrap_evt", int'(evt_data), 'h100);
    cmp("lit_wrap_cnt", int'(wrap_cnt), 1);
    sample(4'd1); sample(4'd2);
    cmp("lit_locked1", int'(locked), 1);
    cmp("lit_err0", int'(err_cnt), 0);

    // 2: jump and resync
    sample(4'd3); sample(4'd4); sample(4'd5); sample(4'd9);
    cmp("lit_err_evt", int'(evt_data), 'h269);
    cmp("lit_unlocked", int'(locked), 0);
    cmp("lit_err1", int'(err_cnt), 1);
    sample(4'd10);
    cmp("lit_relock_evt", int'(evt_data), 'h3aa);
    cmp("lit_relocked", int'(locked), 1);

    // 3: stalled consumer overflows, drain in order
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) sample(4'd10);
    cmp("lit_overflow", int'(overflow), 1);
    cmp("lit_head_kept", int'(evt_data), 'h3aa);
    cnt_en = 1'b0; evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    clr = 1'b1; step(); clr = 1'b0;

    // 4: push into full FIFO while popping
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(4'd0);
    evt_ready = 1'b1;
    sample(4'd0);
    cmp("lit_no_overflow", int'(overflow), 0);
    cmp("lit_err4", int'(err_cnt), 4);

    // 5: gaps between samples carry garbage
    sample(4'd1);
    seq = 4'd2;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        cnt_en = 1'b1; cnt_in = seq; seq = seq + 4'd1;
      end else begin
        cnt_en = 1'b0; cnt_in = 4'($urandom_range(0, 15));
      end
      step();
    end
    cmp("lit_gap_locked", int'(locked), 1);
    cmp("lit_gap_err", int'(err_cnt), 4);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      cnt_en    = ($urandom_range(0, 3) != 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 199) == 0);
      if (cnt_en) begin
        if ($urandom_range(0, 9) == 0) cnt_in = 4'($urandom_range(0, 15));
        else begin cnt_in = seq; seq = seq + 4'd1; end
      end else cnt_in = 4'($urandom_range(0, 15));
      step();
    end
    clr = 1'b0;

    // 6: asynchronous reset between edges, then clear racing a sample
    sample(4'd7);
    #3 reset = 1'b1;
    #1;
    cmp("async_valid", int'(evt_valid), 0);
    cmp("async_data", int'(evt_data), 0);
    cmp("async_locked", int'(locked), 0);
    cmp("async_wrap", int'(wrap_cnt), 0);
    cmp("async_err", int'(err_cnt), 0);
    cmp("async_ovf", int'(overflow), 0);
    step();
    reset = 1'b0;
    clr = 1'b1; cnt_en = 1'b1; cnt_in = 4'd5;
    step();
    cmp("clr_no_event", int'(evt_valid), 0);
    cmp("clr_unlocked", int'(locked), 0);
    clr = 1'b0;
    sample(4'd6);
    cmp("lit_post_clr_lock", int'(evt_data), 'h366);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
